projectile_pool_ctrl: RTL

Frame-synchronous scheduler that owns a pool of NUM_SLOTS projectile mover instances and shares them between two requesters: the player ship and the alien fleet. It latches fire requests and grants at most one launch per frame. Player shots get a per-frame cooldown and a concurrent-shot limit. It picks the lowest free slot, issues a one-cycle launch pulse with the spawn coordinates, and tracks slot occupancy until each mover reports done.

---
 rtl/projectile_pool_ctrl_if.sv | 39 +++
 rtl/projectile_pool_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/projectile_pool_ctrl_if.sv
// Purpose: request/coordinate inputs and launch/status outputs of the projectile pool controller.
// Latency: none, wires only.
// Backpressure: none; requests are latched by the controller until served.
interface projectile_pool_ctrl_if #(
    parameter int NUM_SLOTS = 4
);
    logic                 player_fire_req;
    logic [10:0]          player_x;
    logic [10:0]          player_y;
    logic                 alien_fire_req;
    logic [10:0]          alien_x;
    logic [10:0]          alien_y;
    logic [NUM_SLOTS-1:0] slot_done;

    logic [NUM_SLOTS-1:0] launch;
    logic [10:0]          launch_x;
    logic [10:0]          launch_y;
    logic                 launch_dir;
    logic [NUM_SLOTS-1:0] slot_busy;
    logic                 player_ack;
    logic                 alien_ack;
    logic                 cooldown_active;

    // Controller side
    modport master (
        input  player_fire_req, player_x, player_y,
        input  alien_fire_req, alien_x, alien_y, slot_done,
        output launch, launch_x, launch_y, launch_dir,
        output slot_busy, player_ack, alien_ack, cooldown_active
    );

    // Requester / mover side
    modport slave (
        output player_fire_req, player_x, player_y,
        output alien_fire_req, alien_x, alien_y, slot_done,
        input  launch, launch_x, launch_y, launch_dir,
        input  slot_busy, player_ack, alien_ack, cooldown_active
    );
endinterface

// File: rtl/projectile_pool_ctrl.sv
// Purpose: frame-synchronous arbiter sharing NUM_SLOTS projectile movers between player and aliens.
// Latency: launch pulse 2 cycles after startOfFrame; at most one launch per frame.
// Backpressure: requests stay pending while no slot is free, cooldown runs, or enable=0.
// Optional: define PROJ_POOL_STATS_EN to add shots_fired / req_dropped counters.
module projectile_pool_ctrl #(
    parameter int NUM_SLOTS        = 4,
    parameter int COOLDOWN_FRAMES  = 8,
    parameter int MAX_PLAYER_SHOTS = 1,
    parameter int PLAYER_X_OFS     = 15,
    parameter int PLAYER_Y_OFS     = 2,
    parameter int ALIEN_X_OFS      = 8,
    parameter int ALIEN_Y_OFS      = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   enable,
    projectile_pool_ctrl_if.master pif
`ifdef PROJ_POOL_STATS_EN
    ,
    output logic [15:0]            shots_fired,
    output logic [15:0]            req_dropped
`endif
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int NW = $clog2(NUM_SLOTS + 1);
    localparam int CW = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {IDLE_ST, ARB_ST, LAUNCH_ST} state_t;

    state_t               state_q, state_d;
    logic                 pend_p_q, pend_p_d, pend_a_q, pend_a_d;
    logic                 preq_prev_q, preq_prev_d, areq_prev_q, areq_prev_d;
    logic [CW-1:0]        cd_q, cd_d;
    logic [NUM_SLOTS-1:0] busy_q, busy_d, owner_q, owner_d;
    logic                 last_grant_q, last_grant_d;   // 1 = player, 0 = alien
    logic                 gnt_p_q, gnt_p_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [10:0]          x_q, x_d, y_q, y_d;
`ifdef PROJ_POOL_STATS_EN
    logic [15:0]          shots_q, shots_d, drop_q, drop_d;
`endif

    logic                 p_rise, a_rise, p_elig, a_elig, grant_p, any_elig, free_vld;
    logic [SW-1:0]        free_idx;
    logic [NW-1:0]        p_busy_cnt;
    logic [11:0]          px_sum, py_dif, ax_sum, ay_sum;
    logic [10:0]          px_sat, py_clp, ax_sat, ay_sat;
    logic [NUM_SLOTS-1:0] launch_c;

    // Eligibility, lowest free slot, fairness pick and saturated spawn coordinates
    always_comb begin
        p_busy_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            p_busy_cnt = p_busy_cnt + NW'(busy_q[i] & owner_q[i]);
        end
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_vld = 1'b1;
                free_idx = SW'(i);
            end
        end
        p_elig   = pend_p_q && (cd_q == '0) && (int'(p_busy_cnt) < MAX_PLAYER_SHOTS);
        a_elig   = pend_a_q;
        any_elig = p_elig || a_elig;
        // On a tie the requester not served last time wins
        grant_p  = p_elig && (!a_elig || !last_grant_q);

        px_sum = {1'b0, pif.player_x} + 12'(PLAYER_X_OFS);
        py_dif = {1'b0, pif.player_y} - 12'(PLAYER_Y_OFS);
        ax_sum = {1'b0, pif.alien_x} + 12'(ALIEN_X_OFS);
        ay_sum = {1'b0, pif.alien_y} + 12'(ALIEN_Y_OFS);
        px_sat = px_sum[11] ? 11'h7FF : px_sum[10:0];
        py_clp = py_dif[11] ? 11'h000 : py_dif[10:0];
        ax_sat = ax_sum[11] ? 11'h7FF : ax_sum[10:0];
        ay_sat = ay_sum[11] ? 11'h7FF : ay_sum[10:0];
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE_ST;
        else         state_q <= state_d;
    end

    // FSM next state: SOF outside IDLE_ST is dropped, not queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_ST:   if (startOfFrame && enable) state_d = ARB_ST;
            ARB_ST:    state_d = (any_elig && free_vld) ? LAUNCH_ST : IDLE_ST;
            LAUNCH_ST: state_d = IDLE_ST;
            default:   state_d = IDLE_ST;
        endcase
    end

    // FSM outputs: launch fields are only non-zero during the LAUNCH_ST cycle
    always_comb begin
        launch_c           = '0;
        pif.launch_x       = '0;
        pif.launch_y       = '0;
        pif.launch_dir     = 1'b0;
        pif.player_ack     = 1'b0;
        pif.alien_ack      = 1'b0;
        if (state_q == LAUNCH_ST) begin
            launch_c[slot_q] = 1'b1;
            pif.launch_x     = x_q;
            pif.launch_y     = y_q;
            pif.launch_dir   = !gnt_p_q;
            pif.player_ack   = gnt_p_q;
            pif.alien_ack    = !gnt_p_q;
        end
        pif.launch          = launch_c;
        pif.slot_busy       = busy_q;
        pif.cooldown_active = (cd_q != '0);
    end

    // Datapath next values: request latching, occupancy, cooldown, grant capture
    always_comb begin
        p_rise       = pif.player_fire_req & ~preq_prev_q;
        a_rise       = pif.alien_fire_req & ~areq_prev_q;
        preq_prev_d  = pif.player_fire_req;
        areq_prev_d  = pif.alien_fire_req;
        pend_p_d     = pend_p_q | p_rise;
        pend_a_d     = pend_a_q | a_rise;
        busy_d       = busy_q & ~pif.slot_done;
        owner_d      = owner_q & ~pif.slot_done;
        cd_d         = cd_q;
        last_grant_d = last_grant_q;
        gnt_p_d      = gnt_p_q;
        slot_d       = slot_q;
        x_d          = x_q;
        y_d          = y_q;
`ifdef PROJ_POOL_STATS_EN
        shots_d      = shots_q;
        drop_d       = drop_q;
`endif
        case (state_q)
            IDLE_ST: begin
                if (startOfFrame && enable && (cd_q != '0)) cd_d = cd_q - 1'b1;
            end
            ARB_ST: begin
                if (any_elig && free_vld) begin
                    gnt_p_d = grant_p;
                    slot_d  = free_idx;
                    x_d     = grant_p ? px_sat : ax_sat;
                    y_d     = grant_p ? py_clp : ay_sat;
                end
`ifdef PROJ_POOL_STATS_EN
                if (any_elig && !free_vld && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
`endif
            end
            LAUNCH_ST: begin
                busy_d[slot_q] = 1'b1;
                last_grant_d   = gnt_p_q;
                if (gnt_p_q) begin
                    owner_d[slot_q] = 1'b1;
                    pend_p_d        = p_rise;
                    cd_d            = CW'(COOLDOWN_FRAMES);
                end else begin
                    pend_a_d        = a_rise;
                end
`ifdef PROJ_POOL_STATS_EN
                if (shots_q != 16'hFFFF) shots_d = shots_q + 16'd1;
`endif
            end
            default: ;
        endcase
    end

    // Datapath registers; reset frees every slot at once
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_p_q     <= 1'b0;
            pend_a_q     <= 1'b0;
            preq_prev_q  <= 1'b0;
            areq_prev_q  <= 1'b0;
            cd_q         <= '0;
            busy_q       <= '0;
            owner_q      <= '0;
            last_grant_q <= 1'b0;
            gnt_p_q      <= 1'b0;
            slot_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
`ifdef PROJ_POOL_STATS_EN
            shots_q      <= '0;
            drop_q       <= '0;
`endif
        end else begin
            pend_p_q     <= pend_p_d;
            pend_a_q     <= pend_a_d;
            preq_prev_q  <= preq_prev_d;
            areq_prev_q  <= areq_prev_d;
            cd_q         <= cd_d;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            gnt_p_q      <= gnt_p_d;
            slot_q       <= slot_d;
            x_q          <= x_d;
            y_q          <= y_d;
`ifdef PROJ_POOL_STATS_EN
            shots_q      <= shots_d;
            drop_q       <= drop_d;
`endif
        end
    end

`ifdef PROJ_POOL_STATS_EN
    assign shots_fired = shots_q;
    assign req_dropped = drop_q;
`endif
endmodule
